// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer read-back path: default resolution,
// width helpers and the dumper state encoding.
package frame_buffer_pkg;

    localparam int unsigned DEF_HOR_ACTIVE_PIXELS = 640;
    localparam int unsigned DEF_VER_ACTIVE_PIXELS = 480;
    localparam int unsigned DEF_PIXELS_PER_WORD   = 8;
    localparam int unsigned DEF_READ_LATENCY      = 1;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned addr_width(input int unsigned h, input int unsigned v);
        return clog2_min1(h * v);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SEND  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/pixel_packer.sv
// Word assembly for the dumper: tracks which slot each in-flight read belongs to
// and drops returning pixels into the word register after READ_LATENCY cycles.
module pixel_packer
    import frame_buffer_pkg::*;
#(
    parameter int unsigned PIXELS_PER_WORD = DEF_PIXELS_PER_WORD,
    parameter int unsigned READ_LATENCY    = DEF_READ_LATENCY
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       issue_i,
    input  logic                       read_data_i,
    output logic [PIXELS_PER_WORD-1:0] word_o,
    output logic                       slot_last_c,
    output logic                       drain_done_c
);

    localparam int unsigned SLOT_W = clog2_min1(PIXELS_PER_WORD);

    logic [SLOT_W-1:0]                    slot_q, slot_d;
    logic [READ_LATENCY-1:0]              vpipe_q, vpipe_d;
    logic [READ_LATENCY-1:0][SLOT_W-1:0]  spipe_q, spipe_d;
    logic [PIXELS_PER_WORD-1:0]           word_q, word_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            vpipe_q <= '0;
            spipe_q <= '0;
            word_q  <= '0;
        end else begin
            slot_q  <= slot_d;
            vpipe_q <= vpipe_d;
            spipe_q <= spipe_d;
            word_q  <= word_d;
        end
    end

    // Pad slots are never written, so clearing the word zero-fills them
    always_comb begin
        slot_d     = slot_q;
        vpipe_d    = '0;
        spipe_d    = '0;
        word_d     = word_q;
        vpipe_d[0] = issue_i;
        spipe_d[0] = slot_q;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            spipe_d[i] = spipe_q[i-1];
        end
        if (clear_i) begin
            slot_d = '0;
            word_d = '0;
        end else begin
            if (issue_i) begin
                slot_d = slot_q + SLOT_W'(1);
            end
            if (vpipe_q[READ_LATENCY-1]) begin
                word_d[spipe_q[READ_LATENCY-1]] = read_data_i;
            end
        end
    end

    // During drain only the word's final read remains once it reaches the last stage
    assign drain_done_c = (vpipe_q == (READ_LATENCY'(1) << (READ_LATENCY - 1)));
    assign slot_last_c  = (slot_q == SLOT_W'(PIXELS_PER_WORD - 1));
    assign word_o       = word_q;

endmodule

// File: rtl/frame_buffer_dumper.sv
// Raster-order read-back of the 1-bit frame buffer, packed into words and
// streamed over valid/ready; holds off buffer swaps while a dump is running.
module frame_buffer_dumper
    import frame_buffer_pkg::*;
#(
    parameter  int unsigned HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
    parameter  int unsigned VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
    parameter  int unsigned PIXELS_PER_WORD   = DEF_PIXELS_PER_WORD,
    parameter  int unsigned READ_LATENCY      = DEF_READ_LATENCY,
    localparam int unsigned ADDR_WIDTH        = addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       ready,
    output logic [ADDR_WIDTH-1:0]      read_addr,
    input  logic                       read_data,
    output logic [PIXELS_PER_WORD-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last_in_row,
    output logic                       frame_hold,
    output logic                       frame_done
);

    localparam int unsigned XW        = clog2_min1(HOR_ACTIVE_PIXELS);
    localparam int unsigned YW        = clog2_min1(VER_ACTIVE_PIXELS);
    localparam int unsigned LAST_ADDR = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS - 1;

    dump_state_e           state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  row_end_q, row_end_d;
    logic                  frame_end_q, frame_end_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;

    logic issue_c;
    logic clear_c;
    logic slot_last_c;
    logic drain_done_c;
    logic row_last_px_c;
    logic frame_last_row_c;

    pixel_packer #(
        .PIXELS_PER_WORD (PIXELS_PER_WORD),
        .READ_LATENCY    (READ_LATENCY)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_c),
        .issue_i      (issue_c),
        .read_data_i  (read_data),
        .word_o       (out_data),
        .slot_last_c  (slot_last_c),
        .drain_done_c (drain_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            row_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            row_end_q   <= row_end_d;
            frame_end_q <= frame_end_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
        end
    end

    assign row_last_px_c    = (x_q == XW'(HOR_ACTIVE_PIXELS - 1));
    assign frame_last_row_c = (y_q == YW'(VER_ACTIVE_PIXELS - 1));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        row_end_d   = row_end_q;
        frame_end_d = frame_end_q;
        done_d      = 1'b0;
        issue_c     = 1'b0;
        clear_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    clear_c = 1'b1;
                end
            end
            ST_FETCH: begin
                issue_c = 1'b1;
                if (row_last_px_c) begin
                    x_d = '0;
                    if (!frame_last_row_c) begin
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
                // Address stops at the last pixel instead of wrapping
                if (addr_q != ADDR_WIDTH'(LAST_ADDR)) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
                if (slot_last_c || row_last_px_c) begin
                    state_d     = ST_DRAIN;
                    row_end_d   = row_last_px_c;
                    frame_end_d = row_last_px_c && frame_last_row_c;
                end
            end
            ST_DRAIN: begin
                if (drain_done_c) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    clear_c = 1'b1;
                    if (frame_end_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        hold_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_SEND);
        last_d  = (state_d == ST_SEND) && row_end_d;
    end

    assign ready           = ready_q;
    assign read_addr       = addr_q;
    assign out_valid       = valid_q;
    assign out_last_in_row = last_q;
    assign frame_hold      = hold_q;
    assign frame_done      = done_q;

endmodule

// File: tb/tb_frame_buffer_dumper.sv
// Directed bench: 10x3 frame, 4 pixels per word, read latencies 1 and 3,
// RAM contents pixel = (x+y) mod 2.
module tb_frame_buffer_dumper;

    logic clk;
    logic rst;
    logic sink_ready;
    bit   sel_b;
    int   total;
    int   bad;

    logic       start_a, ready_a, rd_a, valid_a, last_a, hold_a, done_a;
    logic [4:0] addr_a;
    logic [3:0] data_a;
    logic       start_b, ready_b, rd_b, valid_b, last_b, hold_b, done_b;
    logic [4:0] addr_b;
    logic [3:0] data_b;
    logic       rb1, rb2;

    logic       cur_valid, cur_hold, cur_done, cur_last;
    logic [4:0] cur_addr;
    logic [3:0] cur_data;

    logic [3:0] got_words[$];
    logic       got_last[$];
    int         got_addr[$];
    int         cyc_done, first_valid, stall_bad, hold_bad;

    frame_buffer_dumper #(
        .HOR_ACTIVE_PIXELS (10), .VER_ACTIVE_PIXELS (3),
        .PIXELS_PER_WORD (4), .READ_LATENCY (1)
    ) u_dut_a (
        .clk (clk), .rst (rst), .start (start_a), .ready (ready_a),
        .read_addr (addr_a), .read_data (rd_a), .out_data (data_a),
        .out_valid (valid_a), .out_ready (sink_ready), .out_last_in_row (last_a),
        .frame_hold (hold_a), .frame_done (done_a)
    );

    frame_buffer_dumper #(
        .HOR_ACTIVE_PIXELS (10), .VER_ACTIVE_PIXELS (3),
        .PIXELS_PER_WORD (4), .READ_LATENCY (3)
    ) u_dut_b (
        .clk (clk), .rst (rst), .start (start_b), .ready (ready_b),
        .read_addr (addr_b), .read_data (rd_b), .out_data (data_b),
        .out_valid (valid_b), .out_ready (sink_ready), .out_last_in_row (last_b),
        .frame_hold (hold_b), .frame_done (done_b)
    );

    function automatic logic pix(input int unsigned a);
        return 1'(((a % 10) + (a / 10)) % 2);
    endfunction

    function automatic logic [3:0] golden(input int w);
        logic [3:0] r;
        int row, x;
        r = '0;
        row = w / 3;
        for (int i = 0; i < 4; i++) begin
            x = (w % 3) * 4 + i;
            if (x < 10) r[i] = 1'((x + row) % 2);
        end
        return r;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: one-cycle and three-cycle read latency
    always @(posedge clk) begin
        rd_a <= pix(32'(addr_a));
        rb1  <= pix(32'(addr_b));
        rb2  <= rb1;
        rd_b <= rb2;
    end

    always_comb begin
        cur_valid = sel_b ? valid_b : valid_a;
        cur_hold  = sel_b ? hold_b  : hold_a;
        cur_done  = sel_b ? done_b  : done_a;
        cur_last  = sel_b ? last_b  : last_a;
        cur_addr  = sel_b ? addr_b  : addr_a;
        cur_data  = sel_b ? data_b  : data_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records one frame from the selected instance until frame_done (or budget)
    task automatic capture(input bit stall, output bit timeout);
        logic [3:0] pd;
        int pa;
        bit stalled;
        got_words.delete();
        got_last.delete();
        got_addr.delete();
        stall_bad = 0; hold_bad = 0; first_valid = -1; cyc_done = -1;
        stalled = 1'b0; pd = '0; pa = 0; timeout = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            sink_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cur_done) begin
                cyc_done = c;
                timeout  = 1'b0;
                break;
            end
            if (!cur_hold) hold_bad++;
            if (got_addr.size() == 0 || got_addr[$] != int'(cur_addr)) got_addr.push_back(int'(cur_addr));
            if (stalled && (cur_data !== pd || int'(cur_addr) != pa || cur_valid !== 1'b1)) stall_bad++;
            if (cur_valid && first_valid < 0) first_valid = c;
            stalled = cur_valid && !sink_ready;
            pd = cur_data;
            pa = int'(cur_addr);
            if (cur_valid && sink_ready) begin
                got_words.push_back(cur_data);
                got_last.push_back(cur_last);
            end
            tick();
        end
        sink_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total += 8;
        if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_a); end
        if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        if (data_a !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_a); end
        if (addr_a !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
        if (last_a !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", last_a); end
        if (hold_a !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b exp=0", hold_a); end
        if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
        if (ready_b !== 1'b1) begin bad++; $display("FAIL reset_ready_b got=%b exp=1", ready_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        bit to;
        logic [3:0] gw;
        int ga;
        sel_b = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        total += 3;
        if (ready_a !== 1'b0) begin bad++; $display("FAIL accept_ready got=%b exp=0", ready_a); end
        if (hold_a !== 1'b1) begin bad++; $display("FAIL accept_hold got=%b exp=1", hold_a); end
        if (addr_a !== 5'd0) begin bad++; $display("FAIL accept_addr got=%0d exp=0", addr_a); end
        capture(1'b0, to);
        total += 7;
        if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", to); end
        if (got_words.size() != 9) begin bad++; $display("FAIL basic_count got=%0d exp=9", got_words.size()); end
        if (cyc_done != 48) begin bad++; $display("FAIL basic_cycles got=%0d exp=48", cyc_done); end
        if (first_valid != 5) begin bad++; $display("FAIL basic_first_valid got=%0d exp=5", first_valid); end
        if (hold_bad != 0) begin bad++; $display("FAIL basic_hold_drop got=%0d exp=0", hold_bad); end
        if (ready_a !== 1'b1) begin bad++; $display("FAIL done_ready got=%b exp=1", ready_a); end
        if (hold_a !== 1'b0) begin bad++; $display("FAIL done_hold got=%b exp=0", hold_a); end
        gw = (got_words.size() > 2) ? got_words[2] : 4'bx;
        total++;
        if (gw !== 4'b0010) begin bad++; $display("FAIL row0_word2 got=%b exp=0010", gw); end
        for (int w = 0; w < 9; w++) begin
            gw = (w < got_words.size()) ? got_words[w] : 4'bx;
            total += 2;
            if (gw !== golden(w)) begin bad++; $display("FAIL basic_word%0d got=%b exp=%b", w, gw, golden(w)); end
            if (w < got_last.size() && got_last[w] !== (w % 3 == 2)) begin
                bad++; $display("FAIL basic_last%0d got=%b exp=%b", w, got_last[w], (w % 3 == 2));
            end
        end
        total++;
        if (got_addr.size() != 30) begin bad++; $display("FAIL addr_count got=%0d exp=30", got_addr.size()); end
        for (int i = 0; i < 30; i++) begin
            ga = (i < got_addr.size()) ? got_addr[i] : -1;
            total++;
            if (ga != i) begin bad++; $display("FAIL addr_seq%0d got=%0d exp=%0d", i, ga, i); end
        end
        tick();
        total++;
        if (done_a !== 1'b0) begin bad++; $display("FAIL done_once got=%b exp=0", done_a); end
    endtask

    task automatic test_latency3();
        bit to;
        logic [3:0] gw;
        sel_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        capture(1'b0, to);
        total += 4;
        if (to !== 1'b0) begin bad++; $display("FAIL l3_timeout got=%b exp=0", to); end
        if (got_words.size() != 9) begin bad++; $display("FAIL l3_count got=%0d exp=9", got_words.size()); end
        if (cyc_done != 66) begin bad++; $display("FAIL l3_cycles got=%0d exp=66", cyc_done); end
        if (first_valid != 7) begin bad++; $display("FAIL l3_first_valid got=%0d exp=7", first_valid); end
        for (int w = 0; w < 9; w++) begin
            gw = (w < got_words.size()) ? got_words[w] : 4'bx;
            total++;
            if (gw !== golden(w)) begin bad++; $display("FAIL l3_word%0d got=%b exp=%b", w, gw, golden(w)); end
        end
        sel_b = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        bit to;
        logic [3:0] gw;
        sel_b = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        capture(1'b1, to);
        total += 4;
        if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout got=%b exp=0", to); end
        if (stall_bad != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", stall_bad); end
        if (got_words.size() != 9) begin bad++; $display("FAIL stall_count got=%0d exp=9", got_words.size()); end
        if (got_addr.size() != 30) begin bad++; $display("FAIL stall_addr_count got=%0d exp=30", got_addr.size()); end
        for (int w = 0; w < 9; w++) begin
            gw = (w < got_words.size()) ? got_words[w] : 4'bx;
            total++;
            if (gw !== golden(w)) begin bad++; $display("FAIL stall_word%0d got=%b exp=%b", w, gw, golden(w)); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit to, reached;
        int n, dones;
        logic [3:0] gw;
        sink_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (valid_a) n++;
            if (n == 4) begin reached = 1'b1; break; end
            tick();
        end
        total++;
        if (reached !== 1'b1) begin bad++; $display("FAIL mid_reach got=%0d exp=4", n); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 7;
        if (ready_a !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", ready_a); end
        if (valid_a !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", valid_a); end
        if (data_a !== 4'h0) begin bad++; $display("FAIL mid_data got=%h exp=0", data_a); end
        if (addr_a !== 5'd0) begin bad++; $display("FAIL mid_addr got=%0d exp=0", addr_a); end
        if (last_a !== 1'b0) begin bad++; $display("FAIL mid_last got=%b exp=0", last_a); end
        if (hold_a !== 1'b0) begin bad++; $display("FAIL mid_hold got=%b exp=0", hold_a); end
        if (done_a !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done_a); end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_a) dones++;
            tick();
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        capture(1'b0, to);
        total += 2;
        if (to !== 1'b0) begin bad++; $display("FAIL mid_restart_timeout got=%b exp=0", to); end
        if (got_words.size() != 9) begin bad++; $display("FAIL mid_restart_count got=%0d exp=9", got_words.size()); end
        for (int w = 0; w < 9; w++) begin
            gw = (w < got_words.size()) ? got_words[w] : 4'bx;
            total++;
            if (gw !== golden(w)) begin bad++; $display("FAIL mid_word%0d got=%b exp=%b", w, gw, golden(w)); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [3:0] gw;
        start_a = 1'b1;
        tick();
        capture(1'b0, to);
        total += 5;
        if (to !== 1'b0) begin bad++; $display("FAIL b2b_first_timeout got=%b exp=0", to); end
        if (got_words.size() != 9) begin bad++; $display("FAIL b2b_first_count got=%0d exp=9", got_words.size()); end
        if (hold_bad != 0) begin bad++; $display("FAIL b2b_first_hold got=%0d exp=0", hold_bad); end
        if (ready_a !== 1'b1) begin bad++; $display("FAIL b2b_done_ready got=%b exp=1", ready_a); end
        if (hold_a !== 1'b0) begin bad++; $display("FAIL b2b_done_hold got=%b exp=0", hold_a); end
        tick();
        start_a = 1'b0;
        total += 3;
        if (hold_a !== 1'b1) begin bad++; $display("FAIL b2b_restart_hold got=%b exp=1", hold_a); end
        if (ready_a !== 1'b0) begin bad++; $display("FAIL b2b_restart_ready got=%b exp=0", ready_a); end
        if (addr_a !== 5'd0) begin bad++; $display("FAIL b2b_restart_addr got=%0d exp=0", addr_a); end
        capture(1'b0, to);
        total += 3;
        if (to !== 1'b0) begin bad++; $display("FAIL b2b_second_timeout got=%b exp=0", to); end
        if (got_words.size() != 9) begin bad++; $display("FAIL b2b_second_count got=%0d exp=9", got_words.size()); end
        if (hold_bad != 0) begin bad++; $display("FAIL b2b_second_hold got=%0d exp=0", hold_bad); end
        for (int w = 0; w < 9; w++) begin
            gw = (w < got_words.size()) ? got_words[w] : 4'bx;
            total++;
            if (gw !== golden(w)) begin bad++; $display("FAIL b2b_word%0d got=%b exp=%b", w, gw, golden(w)); end
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sink_ready = 1'b1;
        sel_b = 1'b0;
        #1;
        test_reset();
        test_basic_frame();
        test_latency3();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_dumper.md
# frame_buffer_dumper

Sequential read-back engine that sweeps the frame buffer read port in raster order, packs 1-bit pixels into words and streams them over a valid/ready interface for off-chip transfer (UART/SPI bridge) or bench capture. It replaces the ad-hoc per-pixel address sweep with a parametrised, back-pressure-aware block. It is generalised in resolution, word width and read latency. While a dump runs it asserts `frame_hold` so `logic_` defers `swap` and the dump is frame-coherent.

## Interface
- `HOR_ACTIVE_PIXELS`, 640, pixels per row.
- `VER_ACTIVE_PIXELS`, 480, rows per frame.
- `PIXELS_PER_WORD`, 8, pixels packed per output word (1..32).
- `READ_LATENCY`, 1, cycles from `read_addr` to valid `read_data` (1..4).
- Derived: `ADDR_WIDTH = $clog2(H*V)`, `WORDS_PER_ROW = ceil(H / PIXELS_PER_WORD)`.

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a dump; sampled only when `ready`=1.
- `ready`  out  1  idle, able to accept `start`.
- `read_addr`  out  ADDR_WIDTH  frame buffer read address.
- `read_data`  in  1  frame buffer read data.
- `out_data`  out  PIXELS_PER_WORD  packed pixels; bit i = pixel x0+i (LSB first).
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts the word.
- `out_last_in_row`  out  1  current word is the final word of a row.
- `frame_hold`  out  1  high from `start` acceptance until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after the last word handshake.

## Operation
- States: IDLE, FETCH, DRAIN, SEND.
- IDLE: `ready`=1. On `start` go to FETCH, zero x, y and the address counter, and set `frame_hold`.
- FETCH: issue one address per cycle for the real pixels of the current word. The address counter increments; no multiplier. After the word's last real pixel, go to DRAIN.
- DRAIN: wait until all `READ_LATENCY` captures land, via a valid shift register, then go to SEND.
- Capture: the pixel arriving `READ_LATENCY` cycles after its address goes to its bit slot.
- Padding: when H is not a multiple of P, the final word of a row carries `H mod P` real pixels. Pad bits are 0 and no read is issued for pad bits.
- SEND: `out_valid`=1. `out_data` and `out_last_in_row` are held stable until `out_valid && out_ready`.
  - On the handshake, if more words remain, clear the word register and return to FETCH.
  - On the handshake of the frame's final word, pulse `frame_done`, clear `frame_hold` and go to IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `ready`=1, `out_valid`=0, `out_data`=0, `read_addr`=0, `out_last_in_row`=0, `frame_hold`=0, `frame_done`=0. State = IDLE.
- `rst` mid-dump aborts at the next edge. No `frame_done` pulse is emitted and in-flight captures are discarded.
- `start` accepted at edge N: `ready`=0 and `frame_hold`=1 from N+1. The first address is valid from N+1.
- Per word, with sink always ready: n real-pixel fetch cycles, then `READ_LATENCY` drain cycles, then 1 SEND cycle. For full words this is P + L + 1 cycles.
- Back-pressure: the block stays in SEND indefinitely and issues no addresses while stalled.
- `frame_done` is asserted in the cycle after the final handshake, and `ready`=1 in that same cycle.
- A `start` in the `frame_done` cycle is accepted (back-to-back dumps).
- Address wrap: the counter never exceeds H·V−1. The final address is H·V−1.

## Structure
- Shared package `frame_buffer_pkg`: resolution defaults, `ADDR_WIDTH` function, state enum for the dumper.
- One sub-module, `pixel_packer`, holds the word register, slot index, zero padding and `READ_LATENCY` valid pipe. The FSM and counters stay in `frame_buffer_dumper`.

## Test plan
- Parameters H=10, V=3, P=4, L=1. Use a behavioural RAM model holding pixel = (x+y) mod 2. The sink is always ready.
  - Expect 9 words.
  - Row 0 words: 0b1010, 0b1010, 0b0010, with `out_last_in_row` on the third word.
  - `frame_done` fires once.
  - The addresses issued are exactly 0..29, each once.
- Same parameters with L=3: identical word stream. Each full word takes 8 cycles in the FETCH→SEND span.
- Random `out_ready` stalls (50%): `out_data` stays stable while stalled. No address is issued in SEND. The stream matches the stall-free run.
- `rst` asserted mid-row 1: all outputs return to reset values next cycle and there is no `frame_done`. A following `start` produces the full 9-word frame.
- `start` held high for the whole dump plus one cycle: a second dump begins in the `frame_done` cycle. `frame_hold` stays 1 across the boundary except when deasserted for that cycle.
- Defaults (640×480, P=8, all-ones RAM): 38400 words, each 0xFF. `out_last_in_row` every 80th word.
